// File: rtl/rpm_meter_if.sv
// rpm_meter_if: groups the tach input and measurement outputs of rpm_meter.
//   pulse        asynchronous tach input, rising edge = one pulse
//   period       averaged pulse interval in clk cycles
//   period_valid one-cycle strobe when period updates
//   rpm          DIV_CONST / period, truncated
//   rpm_valid    one-cycle strobe when rpm updates
//   stalled      no pulse edge seen within the timeout window
//   busy         divider is running
// master: the meter itself; slave: the tach source / display side.
interface rpm_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pulse;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic [WIDTH-1:0] rpm;
    logic             rpm_valid;
    logic             stalled;
    logic             busy;

    modport master (
        input  pulse,
        output period, period_valid, rpm, rpm_valid, stalled, busy
    );

    modport slave (
        output pulse,
        input  period, period_valid, rpm, rpm_valid, stalled, busy
    );
endinterface

// File: rtl/rpm_meter.sv
// rpm_meter: measures the clk-cycle interval between rising edges of an
// asynchronous tach pulse, averages the last 2^AVG_LOG2 intervals with a
// running sum, and converts the average period to RPM with a sequential
// restoring divider (one quotient bit per cycle).
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    rpm_meter_if.master (pulse in; period/rpm/strobes/stalled/busy out)
module rpm_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned DIV_CONST   = 720000000,
    parameter int unsigned TIMEOUT     = 12000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rpm_meter_if.master bus
);
    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int unsigned SW = WIDTH + AVG_LOG2;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned FW = AVG_LOG2 + 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } div_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   sync_qq;
    logic                   pulse_edge;

    assign sync_q     = sync_r[SYNC_STAGES-1];
    assign pulse_edge = sync_q & ~sync_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= '0;
            sync_qq <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.pulse};
            sync_qq <= sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Interval timer and stall detection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] timer;
    logic             stalled_r;
    logic             first_edge;
    logic             stall_evt;
    logic             sample;

    // An edge in the timeout cycle wins, so a stall needs a quiet cycle.
    assign stall_evt = !pulse_edge && !stalled_r && (timer >= WIDTH'(TIMEOUT));
    assign sample    = pulse_edge && !first_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (pulse_edge) begin
            timer <= WIDTH'(1);
        end else if (stalled_r || stall_evt) begin
            timer <= timer;
        end else if (timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Ring buffer, running sum and averaged period
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    sbuf [N];
    logic [AVG_LOG2-1:0] idx;
    logic [FW-1:0]       fill;
    logic [SW-1:0]       sum;
    logic                avg_req;
    logic [WIDTH-1:0]    period_r;
    logic                period_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                sbuf[i] <= '0;
            end
            idx            <= '0;
            fill           <= '0;
            sum            <= '0;
            avg_req        <= 1'b0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
            stalled_r      <= 1'b1;
            first_edge     <= 1'b1;
        end else if (stall_evt) begin
            for (int unsigned i = 0; i < N; i++) begin
                sbuf[i] <= '0;
            end
            idx            <= '0;
            fill           <= '0;
            sum            <= '0;
            avg_req        <= 1'b0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
            stalled_r      <= 1'b1;
            first_edge     <= 1'b1;
        end else begin
            period_valid_r <= 1'b0;
            avg_req        <= 1'b0;

            if (pulse_edge) begin
                stalled_r  <= 1'b0;
                first_edge <= 1'b0;
            end

            if (sample) begin
                sbuf[idx] <= timer;
                idx       <= idx + 1'b1;
                sum       <= sum + SW'(timer) - SW'(sbuf[idx]);
                if (fill != FW'(N)) begin
                    fill <= fill + 1'b1;
                end
                // Buffer is full once this sample lands.
                avg_req <= (fill >= FW'(N - 1));
            end

            // Sum was updated on the sample cycle; divide it one cycle later.
            if (avg_req) begin
                period_r       <= sum[SW-1:AVG_LOG2];
                period_valid_r <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider FSM
    // ------------------------------------------------------------------
    div_state_t       state;
    div_state_t       state_next;
    logic             div_load;
    logic             div_step;
    logic             div_last;
    logic             pending;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rpm_r;
    logic             rpm_valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request waiting at the last RUN step reloads straight away so busy
    // stays high across back-to-back divisions.
    always_comb begin
        state_next = state;
        div_load   = 1'b0;
        div_step   = 1'b0;
        div_last   = 1'b0;
        if (stall_evt) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (period_valid_r || pending) begin
                        div_load   = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    div_step = 1'b1;
                    if (step_cnt == CW'(WIDTH - 1)) begin
                        div_last = 1'b1;
                        if (period_valid_r || pending) begin
                            div_load = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Restoring step: shift next dividend bit into the remainder, subtract
    // when it fits. The true remainder is below the divisor, so WIDTH bits
    // of the difference are exact. A zero divisor always fits -> all ones.
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, divisor});
        rem_next  = rem_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], 1'b0};
        if (rem_ge) begin
            rem_next = rem_shift[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            step_cnt    <= '0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            rpm_r       <= '0;
            rpm_valid_r <= 1'b0;
        end else if (stall_evt) begin
            pending     <= 1'b0;
            step_cnt    <= '0;
            rpm_r       <= '0;
            rpm_valid_r <= 1'b0;
        end else begin
            rpm_valid_r <= div_last;
            if (div_last) begin
                rpm_r <= quo_next;
            end

            if (div_load) begin
                pending <= 1'b0;
            end else if (period_valid_r && state == S_RUN) begin
                pending <= 1'b1;
            end

            if (div_load) begin
                quo      <= WIDTH'(DIV_CONST);
                rem      <= '0;
                divisor  <= period_r;
                step_cnt <= '0;
            end else if (div_step) begin
                quo      <= quo_next;
                rem      <= rem_next;
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.period       = period_r;
    assign bus.period_valid = period_valid_r;
    assign bus.rpm          = rpm_r;
    assign bus.rpm_valid    = rpm_valid_r;
    assign bus.stalled      = stalled_r;
    assign bus.busy         = (state == S_RUN);

endmodule
